mem_stage_access: RTL and testbench

Memory-stage access unit: sits between the EX/MEM pipeline register and the MEM/WB register, and produces the ME_* bundle that MEM/WB captures. It turns load/store instructions into transactions on a request/grant/response data-memory port. It aligns store data and byte strobes and extracts/extends load data. It stalls the upstream pipeline until each memory transaction completes; non-memory instructions pass through with zero added latency.

---
 rtl/mem_stage_access_pkg.sv | 65 ++++++
 rtl/mem_stage_access_if.sv | 23 ++
 rtl/mem_stage_access_load_extract.sv | 33 +++
 rtl/mem_stage_access.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_access.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_access_pkg.sv
// Shared types for the memory-stage access unit: load/store option codes,
// FSM states, byte-strobe constants and the misalignment rule.
package mem_access_pkg;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } load_opt_e;

    typedef enum logic [1:0] {
        ST_SW = 2'd0,
        ST_SB = 2'd1,
        ST_SH = 2'd2
    } store_opt_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [3:0] STRB_WORD    = 4'b1111;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_BYTE0   = 4'b0001;

    // EX/MEM bundle captured while a memory transaction is in flight
    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [2:0]  lopt;
        logic [31:0] pc;
        logic [2:0]  pcsrc;
    } hold_t;

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never trap
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic       is_store,
                                           input logic [2:0] lopt,
                                           input logic [1:0] sopt);
        logic mis;
        mis = (addr_lo != 2'b00);
        if (is_store) begin
            case (sopt)
                ST_SB:   mis = 1'b0;
                ST_SH:   mis = addr_lo[0];
                default: mis = (addr_lo != 2'b00);
            endcase
        end else begin
            case (lopt)
                LD_LB, LD_LBU: mis = 1'b0;
                LD_LH, LD_LHU: mis = addr_lo[0];
                default:       mis = (addr_lo != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_access_if.sv
// Request/grant/response data-memory port between the memory stage and memory.
interface mem_stage_access_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_stage_access_load_extract.sv
// Combinational load lane select and sign/zero extension (little-endian).
module load_extract
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  load_option_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            2'd3:    byteSel = rdata_i[31:24];
            default: byteSel = rdata_i[7:0];
        endcase
        halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (load_option_i)
            LD_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            LD_LBU:  data_o = {24'd0, byteSel};
            LD_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            LD_LHU:  data_o = {16'd0, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_access.sv
// Memory-stage access unit: stalls the pipeline while a load/store runs on the
// data-memory port. Optional trap on misaligned accesses: MEM_MISALIGN_TRAP_EN.
module mem_stage_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              EX_valid,
    input  logic              EX_RegWrite,
    input  logic              EX_MemtoReg,
    input  logic              EX_MemWrite,
    input  logic [31:0]       EX_Alu_Result,
    input  logic [31:0]       EX_Store_Data,
    input  logic [4:0]        EX_WriteReg,
    input  logic [2:0]        EX_load_option,
    input  logic [1:0]        EX_store_option,
    input  logic [31:0]       EX_PC,
    input  logic [2:0]        EX_PCSrc,
    mem_stage_access_if.master mem,
    output logic              stall,
    output logic              ME_valid,
    output logic              ME_RegWrite,
    output logic              ME_MemtoReg,
    output logic [31:0]       ME_Alu_Result,
    output logic [31:0]       ME_Dout,
    output logic [31:0]       ME_PC,
    output logic [4:0]        ME_WriteReg,
    output logic [2:0]        ME_load_option,
    output logic [2:0]        ME_PCSrc,
    output logic              misalign
);

    state_e            state_q, state_d;
    hold_t             hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       dout_q, dout_d;
    logic              mis_q, mis_d;

    logic        memOp;
    logic        trapNow;
    logic [3:0]  stStrb;
    logic [31:0] stData;
    logic [31:0] loadData;

    assign memOp = EX_valid & (EX_MemtoReg | EX_MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trapNow = is_misaligned(EX_Alu_Result[1:0], EX_MemWrite,
                                   EX_load_option, EX_store_option);
`else
    assign trapNow = 1'b0;
`endif

    // Store lane alignment: replicate the narrow datum and enable only its lanes
    always_comb begin
        stStrb = STRB_WORD;
        stData = EX_Store_Data;
        case (EX_store_option)
            ST_SB: begin
                stStrb = STRB_BYTE0 << EX_Alu_Result[1:0];
                stData = {4{EX_Store_Data[7:0]}};
            end
            ST_SH: begin
                stStrb = EX_Alu_Result[1] ? STRB_HALF_HI : STRB_HALF_LO;
                stData = {2{EX_Store_Data[15:0]}};
            end
            default: begin
                stStrb = STRB_WORD;
                stData = EX_Store_Data;
            end
        endcase
    end

    load_extract uLoadExtract (
        .rdata_i       (mem.mem_rdata),
        .addr_lo_i     (hold_q.alu[1:0]),
        .load_option_i (hold_q.lopt),
        .data_o        (loadData)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        dout_d  = dout_q;
        mis_d   = mis_q;

        stall          = 1'b0;
        ME_valid       = 1'b0;
        ME_RegWrite    = 1'b0;
        ME_MemtoReg    = 1'b0;
        ME_Alu_Result  = 32'd0;
        ME_Dout        = 32'd0;
        ME_PC          = 32'd0;
        ME_WriteReg    = 5'd0;
        ME_load_option = 3'd0;
        ME_PCSrc       = 3'd0;

        unique case (state_q)
            S_IDLE: begin
                if (memOp) begin
                    stall            = 1'b1;
                    hold_d.regwrite  = EX_RegWrite;
                    hold_d.memtoreg  = EX_MemtoReg;
                    hold_d.alu       = EX_Alu_Result;
                    hold_d.wreg      = EX_WriteReg;
                    hold_d.lopt      = EX_load_option;
                    hold_d.pc        = EX_PC;
                    hold_d.pcsrc     = EX_PCSrc;
                    addr_d           = {EX_Alu_Result[ADDR_W-1:2], 2'b00};
                    we_d             = EX_MemWrite;
                    wdata_d          = stData;
                    wstrb_d          = stStrb;
                    dout_d           = 32'd0;
                    mis_d            = trapNow;
                    state_d          = trapNow ? S_DONE : S_REQ;
                end else begin
                    ME_valid       = EX_valid;
                    ME_RegWrite    = EX_RegWrite;
                    ME_MemtoReg    = EX_MemtoReg;
                    ME_Alu_Result  = EX_Alu_Result;
                    ME_PC          = EX_PC;
                    ME_WriteReg    = EX_WriteReg;
                    ME_load_option = EX_load_option;
                    ME_PCSrc       = EX_PCSrc;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem.mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid) begin
                    dout_d  = loadData;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ME_valid       = 1'b1;
                ME_RegWrite    = hold_q.regwrite & ~mis_q;
                ME_MemtoReg    = hold_q.memtoreg;
                ME_Alu_Result  = hold_q.alu;
                ME_Dout        = dout_q;
                ME_PC          = hold_q.pc;
                ME_WriteReg    = hold_q.wreg;
                ME_load_option = hold_q.lopt;
                ME_PCSrc       = hold_q.pcsrc;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            dout_q  <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
        end
    end

    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;
    assign misalign      = (state_q == S_DONE) & mis_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access and its load_extract sub-module.
module tb_mem_stage_access;
    import mem_access_pkg::*;

    logic        clock;
    logic        reset;
    logic        EX_valid, EX_RegWrite, EX_MemtoReg, EX_MemWrite;
    logic [31:0] EX_Alu_Result, EX_Store_Data, EX_PC;
    logic [4:0]  EX_WriteReg;
    logic [2:0]  EX_load_option, EX_PCSrc;
    logic [1:0]  EX_store_option;
    logic        stall, ME_valid, ME_RegWrite, ME_MemtoReg, misalign;
    logic [31:0] ME_Alu_Result, ME_Dout, ME_PC;
    logic [4:0]  ME_WriteReg;
    logic [2:0]  ME_load_option, ME_PCSrc;

    logic [31:0] lxData, lxOut;
    logic [1:0]  lxLane;
    logic [2:0]  lxOpt;

    int nChecks = 0;
    int nFails  = 0;

    mem_stage_access_if #(.ADDR_W(32)) memIf ();

    mem_stage_access #(.ADDR_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .EX_valid       (EX_valid),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemtoReg    (EX_MemtoReg),
        .EX_MemWrite    (EX_MemWrite),
        .EX_Alu_Result  (EX_Alu_Result),
        .EX_Store_Data  (EX_Store_Data),
        .EX_WriteReg    (EX_WriteReg),
        .EX_load_option (EX_load_option),
        .EX_store_option(EX_store_option),
        .EX_PC          (EX_PC),
        .EX_PCSrc       (EX_PCSrc),
        .mem            (memIf),
        .stall          (stall),
        .ME_valid       (ME_valid),
        .ME_RegWrite    (ME_RegWrite),
        .ME_MemtoReg    (ME_MemtoReg),
        .ME_Alu_Result  (ME_Alu_Result),
        .ME_Dout        (ME_Dout),
        .ME_PC          (ME_PC),
        .ME_WriteReg    (ME_WriteReg),
        .ME_load_option (ME_load_option),
        .ME_PCSrc       (ME_PCSrc),
        .misalign       (misalign)
    );

    load_extract uLx (
        .rdata_i       (lxData),
        .addr_lo_i     (lxLane),
        .load_option_i (lxOpt),
        .data_o        (lxOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: load/store rules expressed as plain byte arithmetic
    function automatic int loadSize(input logic [2:0] opt);
        if (opt == 3'd1 || opt == 3'd2) return 1;
        if (opt == 3'd3 || opt == 3'd4) return 2;
        return 4;
    endfunction

    function automatic int storeSize(input logic [1:0] opt);
        if (opt == 2'd1) return 1;
        if (opt == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [2:0] opt);
        longint v;
        int size;
        int base;
        size = loadSize(opt);
        base = (int'(lane) / size) * size;
        v = (longint'(word) >> (8 * base)) & ((longint'(1) << (8 * size)) - 1);
        if ((opt == 3'd1 || opt == 3'd3) && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    function automatic logic [3:0] refStrb(input logic [31:0] addr, input logic [1:0] opt);
        logic [3:0] s;
        int size;
        int base;
        size = storeSize(opt);
        base = (int'(addr[1:0]) / size) * size;
        s = 4'd0;
        for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + size);
        return s;
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] data, input logic [1:0] opt);
        logic [31:0] w;
        int size;
        size = storeSize(opt);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % size) +: 8];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] sdata,
                                 input logic [4:0] wreg, input logic [2:0] lopt,
                                 input logic [1:0] sopt, input logic [31:0] pc,
                                 input logic [2:0] pcsrc);
        EX_valid        = v;
        EX_RegWrite     = rw;
        EX_MemtoReg     = m2r;
        EX_MemWrite     = mw;
        EX_Alu_Result   = alu;
        EX_Store_Data   = sdata;
        EX_WriteReg     = wreg;
        EX_load_option  = lopt;
        EX_store_option = sopt;
        EX_PC           = pc;
        EX_PCSrc        = pcsrc;
    endtask

    // One load/store from request through completion, with a responsive memory model
    task automatic runMemOp(input logic isStore, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [2:0] lopt, input logic [1:0] sopt,
                            input logic [31:0] rdata, input int gntDelay, input int rvDelay,
                            input string tag);
        int cyc, reqCycles, rvTimer, expLat, size;
        bit done, expMis;
        logic [31:0] expDout, pc;
        logic [4:0]  wreg;
        logic [2:0]  pcsrc;
        size   = isStore ? storeSize(sopt) : loadSize(lopt);
        expMis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        expMis = (int'(addr[1:0]) % size) != 0;
`endif
        expDout = (isStore || expMis) ? 32'd0 : refLoad(rdata, addr[1:0], lopt);
        expLat  = expMis ? 2 : (isStore ? 3 + gntDelay : 4 + gntDelay + rvDelay);
        wreg    = 5'($urandom);
        pc      = $urandom;
        pcsrc   = 3'($urandom);
        applyStimulus(1'b1, !isStore, !isStore, isStore, addr, sdata, wreg, lopt, sopt, pc, pcsrc);
        cyc = 0; reqCycles = 0; rvTimer = -1; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clock);
            cyc++;
            memIf.mem_gnt    = 1'b0;
            memIf.mem_rvalid = 1'b0;
            memIf.mem_rdata  = $urandom;
            if (memIf.mem_req) begin
                checkOutput({tag, " mem_addr"}, memIf.mem_addr, {addr[31:2], 2'b00});
                checkOutput({tag, " mem_we"}, 32'(memIf.mem_we), 32'(isStore));
                if (isStore) begin
                    checkOutput({tag, " mem_wstrb"}, 32'(memIf.mem_wstrb), 32'(refStrb(addr, sopt)));
                    checkOutput({tag, " mem_wdata"}, memIf.mem_wdata, refWdata(sdata, sopt));
                end
            end
            if (!stall) begin
                done = 1'b1;
                checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat));
                checkOutput({tag, " ME_valid"}, 32'(ME_valid), 32'd1);
                checkOutput({tag, " ME_Dout"}, ME_Dout, expDout);
                checkOutput({tag, " ME_RegWrite"}, 32'(ME_RegWrite), 32'(!isStore && !expMis));
                checkOutput({tag, " ME_MemtoReg"}, 32'(ME_MemtoReg), 32'(!isStore));
                checkOutput({tag, " ME_Alu_Result"}, ME_Alu_Result, addr);
                checkOutput({tag, " ME_WriteReg"}, 32'(ME_WriteReg), 32'(wreg));
                checkOutput({tag, " ME_PC"}, ME_PC, pc);
                checkOutput({tag, " ME_PCSrc"}, 32'(ME_PCSrc), 32'(pcsrc));
                checkOutput({tag, " misalign"}, 32'(misalign), 32'(expMis));
            end else begin
                checkOutput({tag, " bubble ME_valid"}, 32'(ME_valid), 32'd0);
                checkOutput({tag, " bubble ME_RegWrite"}, 32'(ME_RegWrite), 32'd0);
            end
            if (rvTimer > 0) begin
                rvTimer--;
                if (rvTimer == 0) begin
                    memIf.mem_rvalid = 1'b1;
                    memIf.mem_rdata  = rdata;
                    rvTimer          = -1;
                end
            end
            if (memIf.mem_req) begin
                reqCycles++;
                if (reqCycles > gntDelay) begin
                    memIf.mem_gnt = 1'b1;
                    if (!isStore) rvTimer = rvDelay + 1;
                end
            end
        end
        if (!done) begin
            checkOutput({tag, " timeout"}, 32'(cyc), 32'(expLat));
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
        checkOutput({tag, " request cycles"}, 32'(reqCycles), expMis ? 32'd0 : 32'(gntDelay + 1));
        @(posedge clock);
        #1;
        memIf.mem_gnt    = 1'b0;
        memIf.mem_rvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [1:0]  lane;
        logic [2:0]  opt;
        logic [31:0] exp;
    } lxVec_t;

    typedef struct {
        logic        v, rw, m2r, mw;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [31:0] pc;
        logic [2:0]  pcsrc, lopt;
    } ptVec_t;

    lxVec_t lxTab[13];
    ptVec_t ptTab[5];

    initial begin
        lxTab[0]  = '{32'h80FF_7F01, 2'd3, 3'd1, 32'hFFFF_FF80};
        lxTab[1]  = '{32'h80FF_7F01, 2'd0, 3'd1, 32'h0000_0001};
        lxTab[2]  = '{32'h80FF_7F01, 2'd1, 3'd1, 32'h0000_007F};
        lxTab[3]  = '{32'h80FF_7F01, 2'd2, 3'd1, 32'hFFFF_FFFF};
        lxTab[4]  = '{32'h80FF_7F01, 2'd2, 3'd2, 32'h0000_00FF};
        lxTab[5]  = '{32'h8001_0000, 2'd2, 3'd4, 32'h0000_8001};
        lxTab[6]  = '{32'h8001_0000, 2'd2, 3'd3, 32'hFFFF_8001};
        lxTab[7]  = '{32'h8001_0000, 2'd0, 3'd3, 32'h0000_0000};
        lxTab[8]  = '{32'h1234_8765, 2'd0, 3'd3, 32'hFFFF_8765};
        lxTab[9]  = '{32'h1234_8765, 2'd1, 3'd4, 32'h0000_8765};
        lxTab[10] = '{32'hCAFE_F00D, 2'd2, 3'd0, 32'hCAFE_F00D};
        lxTab[11] = '{32'hCAFE_F00D, 2'd1, 3'd5, 32'hCAFE_F00D};
        lxTab[12] = '{32'hCAFE_F00D, 2'd3, 3'd7, 32'hCAFE_F00D};

        ptTab[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 5'd7,  32'h0040_0010, 3'd0, 3'd0};
        ptTab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 5'd3,  32'h0040_0014, 3'd1, 3'd2};
        ptTab[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 5'd0,  32'h0040_0018, 3'd2, 3'd0};
        ptTab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd31, 32'h0040_001C, 3'd7, 3'd4};
        ptTab[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0001, 5'd12, 32'h0040_0020, 3'd3, 3'd6};

        memIf.mem_gnt    = 1'b0;
        memIf.mem_rvalid = 1'b0;
        memIf.mem_rdata  = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset mem_req", 32'(memIf.mem_req), 32'd0);
        checkOutput("reset mem_wstrb", 32'(memIf.mem_wstrb), 32'd0);
        checkOutput("reset mem_addr", memIf.mem_addr, 32'd0);
        checkOutput("reset misalign", 32'(misalign), 32'd0);
        checkOutput("reset ME_valid", 32'(ME_valid), 32'd0);
        checkOutput("reset ME_Dout", ME_Dout, 32'd0);
        reset = 1'b0;

        foreach (lxTab[i]) begin
            lxData = lxTab[i].word;
            lxLane = lxTab[i].lane;
            lxOpt  = lxTab[i].opt;
            #1;
            checkOutput($sformatf("load_extract vec%0d", i), lxOut, lxTab[i].exp);
        end
        for (int i = 0; i < 30; i++) begin
            lxData = $urandom;
            lxLane = 2'($urandom);
            lxOpt  = 3'($urandom);
            #1;
            checkOutput($sformatf("load_extract rand%0d", i), lxOut, refLoad(lxData, lxLane, lxOpt));
        end

        foreach (ptTab[i]) begin
            @(posedge clock);
            #1;
            applyStimulus(ptTab[i].v, ptTab[i].rw, ptTab[i].m2r, ptTab[i].mw, ptTab[i].alu,
                          32'hA5A5_A5A5, ptTab[i].wreg, ptTab[i].lopt, 2'd0, ptTab[i].pc,
                          ptTab[i].pcsrc);
            #1;
            checkOutput($sformatf("pass%0d stall", i), 32'(stall), 32'd0);
            checkOutput($sformatf("pass%0d mem_req", i), 32'(memIf.mem_req), 32'd0);
            checkOutput($sformatf("pass%0d ME_valid", i), 32'(ME_valid), 32'(ptTab[i].v));
            checkOutput($sformatf("pass%0d ME_RegWrite", i), 32'(ME_RegWrite), 32'(ptTab[i].rw));
            checkOutput($sformatf("pass%0d ME_MemtoReg", i), 32'(ME_MemtoReg), 32'(ptTab[i].m2r));
            checkOutput($sformatf("pass%0d ME_Alu_Result", i), ME_Alu_Result, ptTab[i].alu);
            checkOutput($sformatf("pass%0d ME_Dout", i), ME_Dout, 32'd0);
            checkOutput($sformatf("pass%0d ME_WriteReg", i), 32'(ME_WriteReg), 32'(ptTab[i].wreg));
            checkOutput($sformatf("pass%0d ME_PC", i), ME_PC, ptTab[i].pc);
            checkOutput($sformatf("pass%0d ME_PCSrc", i), 32'(ME_PCSrc), 32'(ptTab[i].pcsrc));
            checkOutput($sformatf("pass%0d ME_load_option", i), 32'(ME_load_option), 32'(ptTab[i].lopt));
        end
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);

        runMemOp(1'b0, 32'h0000_0103, 32'd0, 3'd1, 2'd0, 32'h80FF_7F01, 0, 0, "LB 0x103");
        runMemOp(1'b1, 32'h0000_0202, 32'h0000_ABCD, 3'd0, 2'd2, 32'd0, 2, 0, "SH 0x202");
        runMemOp(1'b0, 32'h0000_0006, 32'd0, 3'd4, 2'd0, 32'h8001_0000, 0, 0, "LHU 0x006");
        runMemOp(1'b0, 32'h0000_0006, 32'd0, 3'd3, 2'd0, 32'h8001_0000, 1, 2, "LH 0x006");
        runMemOp(1'b1, 32'h0000_0301, 32'h1234_5678, 3'd0, 2'd1, 32'd0, 0, 0, "SB 0x301");
        runMemOp(1'b0, 32'h0000_0101, 32'd0, 3'd0, 2'd0, 32'h1122_3344, 0, 0, "LW 0x101");

        // Reset while a load is waiting for its response
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd9, 3'd0, 2'd0, 32'd0, 3'd0);
        @(negedge clock);
        checkOutput("rstwait IDLE stall", 32'(stall), 32'd1);
        @(negedge clock);
        checkOutput("rstwait REQ mem_req", 32'(memIf.mem_req), 32'd1);
        memIf.mem_gnt = 1'b1;
        @(negedge clock);
        memIf.mem_gnt = 1'b0;
        checkOutput("rstwait WAIT mem_req", 32'(memIf.mem_req), 32'd0);
        checkOutput("rstwait WAIT stall", 32'(stall), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);
        @(negedge clock);
        checkOutput("rstwait after mem_req", 32'(memIf.mem_req), 32'd0);
        checkOutput("rstwait after stall", 32'(stall), 32'd0);
        checkOutput("rstwait after ME_Dout", ME_Dout, 32'd0);
        reset = 1'b0;
        memIf.mem_rvalid = 1'b1;
        memIf.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clock);
        memIf.mem_rvalid = 1'b0;
        checkOutput("rstwait late rvalid stall", 32'(stall), 32'd0);
        checkOutput("rstwait late rvalid ME_valid", 32'(ME_valid), 32'd0);
        checkOutput("rstwait late rvalid ME_Dout", ME_Dout, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 5'd4, 3'd0, 2'd0, 32'd0, 3'd0);
        #1;
        checkOutput("rstwait ALU ME_Alu_Result", ME_Alu_Result, 32'h0000_1234);
        checkOutput("rstwait ALU ME_valid", 32'(ME_valid), 32'd1);
        checkOutput("rstwait ALU stall", 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);

        for (int i = 0; i < 40; i++) begin
            runMemOp(1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 3), $sformatf("rand%0d", i));
            if (i % 4 == 0) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'(i * 32'h0101_0101), 32'd0, 5'd1, 3'd0,
                              2'd0, 32'd0, 3'd0);
                #1;
                checkOutput($sformatf("rand%0d ALU passthrough", i), ME_Alu_Result,
                            32'(i * 32'h0101_0101));
                @(posedge clock);
                #1;
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0, 2'd0, 32'd0, 3'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
